pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the five-stage RISC-V pipeline. It decides, cycle by cycle, whether each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) loads, holds, or takes a bubble. Inputs are the RAW hazards between ID and later stages, taken branches resolved in EX, and data-memory wait states. It also keeps a saturating stall-cycle counter and a sticky memory-timeout error that halts the pipeline.

## Interface
- MEM_TIMEOUT, default 255: maximum consecutive MEM_WAIT cycles before halt (1..255).
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  5  source registers of the ID-stage instruction
- id_rs1_used, id_rs2_used  in  1  source actually read
- ex_rd  in  5;  ex_reg_en  in  1;  ex_is_load  in  1  — EX-stage destination info
- mem_rd  in  5;  mem_reg_en  in  1  — MEM-stage destination info (used only without forwarding)
- ex_branch_taken  in  1  — branch/jump in EX resolved taken
- mem_req  in  1  — MEM-stage instruction accesses data memory
- mem_ready  in  1  — data memory completes access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  — register load enables
- if_id_flush, id_ex_flush  out  1  — load NOP into register (overrides enable)
- wb_bubble  out  1  — MEM/WB captures a NOP (reg_en=0)
- state  out  2  — RUN=0, MEM_WAIT=1, HALT=2
- stall_cycles  out  16  — saturating count of cycles with pc_en=0 (excluding HALT)
- mem_timeout  out  1  — sticky error

## Operation
- **Hazard detection:** a match requires rd≠0, the producer's reg_en=1, and rsN_used=1 with rsN==rd.
- **Priority in RUN, and in MEM_WAIT on the cycle mem_ready=1.** The highest applicable item wins:
  1. **Memory stall** (mem_req=1, mem_ready=0):
     - pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
     - mem_wb_en=1 with wb_bubble=1.
     - Next state MEM_WAIT.
     - ex_branch_taken is ignored; the branch stays held in EX.
  2. **Taken branch:**
     - All enables = 1.
     - if_id_flush=1, id_ex_flush=1.
     - Data hazard suppressed.
  3. **Data hazard:**
     - pc_en=0, if_id_en=0.
     - id_ex_flush=1.
     - ex_mem_en=1, mem_wb_en=1.
  4. **Otherwise:** all enables 1, flushes 0, wb_bubble 0.
- **MEM_WAIT:**
  - wait_cnt (8-bit) increments each cycle with mem_ready=0.
  - mem_ready=1 → apply priorities 2–4, next RUN, wait_cnt cleared.
  - wait_cnt reaching MEM_TIMEOUT with mem_ready=0 → mem_timeout=1, next HALT.
- **HALT:**
  - All enables 0, flushes 0, wb_bubble 0.
  - Exit only by reset.
  - stall_cycles frozen.
- **stall_cycles:** +1 on each clock edge where pc_en=0 and state≠HALT; holds at 0xFFFF.

## Timing
- All enables/flushes are combinational from state and inputs, with zero-cycle latency; state, wait_cnt, stall_cycles and mem_timeout update on the rising clock.
- **While reset=1:**
  - Enables = 0, if_id_flush=id_ex_flush=1, wb_bubble=1.
  - On the edge: state=RUN, wait_cnt=0, stall_cycles=0, mem_timeout=0.
- **Reset mid-MEM_WAIT or in HALT** returns to RUN on the same edge.
- **Stall durations:**
  - A load-use hazard stalls exactly 1 cycle with forwarding (the load advances to MEM).
  - Without forwarding, an EX-stage producer stalls 2 cycles and a MEM-stage producer stalls 1.
- **Memory stall:** lasts N cycles for N cycles of mem_ready=0; the access completes on the cycle mem_ready=1.
- **Timeout:** with MEM_TIMEOUT=T, HALT is entered on the edge ending the T-th consecutive not-ready cycle.

## Configuration
- **PIPELINE_CTRL_FORWARDING_EN defined:**
  - Only load-use is a data hazard: ex_is_load=1 and an ex_rd match.
  - mem_rd and mem_reg_en are ignored.
- **Undefined:**
  - Any match against ex_rd (regardless of ex_is_load) or mem_rd is a hazard.
  - A WB-stage producer is not a hazard; the register file is write-before-read.

## Test plan
- **Load-use (forwarding):** ex_is_load=1, ex_reg_en=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cycles 0→1.
- **x0 and unused source:** same as above with ex_rd=0, or id_rs1_used=0 → no stall, all enables 1.
- **Memory wait:** mem_req=1, mem_ready=0 for 3 cycles then 1:
  - state=MEM_WAIT after the first edge.
  - wb_bubble=1 for 3 cycles, then RUN.
  - stall_cycles=3.
- **Simultaneous events:**
  - ex_branch_taken=1 with a load-use hazard → flushes asserted, pc_en=1, no stall.
  - ex_branch_taken=1 with a memory stall → stall wins; flush occurs on the cycle mem_ready=1.
- **Timeout:** MEM_TIMEOUT=4, mem_req=1, mem_ready held 0:
  - After 4 MEM_WAIT cycles → mem_timeout=1, state=HALT, all enables 0.
  - stall_cycles stops incrementing.
  - reset → RUN, mem_timeout=0, stall_cycles=0.
- **No forwarding (macro undefined):** ex_is_load=0, ex_reg_en=1, ex_rd=7, id_rs2=7 used → 2 consecutive stall cycles as the producer moves EX→MEM; stall_cycles=2.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline: per-register load enables,
// flushes, memory-wait FSM, saturating stall counter and sticky memory timeout.
// Optional feature: define PIPELINE_CTRL_FORWARDING_EN for a forwarding datapath (load-use only).
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_reg_en_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  mem_rd_i,
  input  logic        mem_reg_en_i,
  input  logic        ex_branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        id_ex_en_o,
  output logic        ex_mem_en_o,
  output logic        mem_wb_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        wb_bubble_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cycles_o,
  output logic        mem_timeout_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic        ex_match, mem_match, data_hazard;
  logic        mem_hold;
  logic [8:0]  wait_inc;
  logic        wait_expired;
  logic        unused_inputs;

  assign ex_match  = (ex_rd_i != '0) && ex_reg_en_i &&
                     ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                      (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
  assign mem_match = (mem_rd_i != '0) && mem_reg_en_i &&
                     ((id_rs1_used_i && (id_rs1_i == mem_rd_i)) ||
                      (id_rs2_used_i && (id_rs2_i == mem_rd_i)));

`ifdef PIPELINE_CTRL_FORWARDING_EN
  assign data_hazard   = ex_is_load_i && ex_match;
  assign unused_inputs = mem_match;
`else
  assign data_hazard   = ex_match || mem_match;
  assign unused_inputs = ex_is_load_i;
`endif

  // In RUN the stall needs an active request; once in MEM_WAIT only mem_ready releases it.
  assign mem_hold     = (state_q == RUN) ? (mem_req_i && !mem_ready_i) : !mem_ready_i;
  assign wait_inc     = {1'b0, wait_cnt_q} + 9'd1;
  assign wait_expired = (wait_inc >= 9'(MEM_TIMEOUT));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_hold) begin
          wait_cnt_d = wait_inc[7:0];
          if (wait_expired) begin
            state_d       = HALT;
            mem_timeout_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_en_o       = 1'b0;
    if_id_en_o    = 1'b0;
    id_ex_en_o    = 1'b0;
    ex_mem_en_o   = 1'b0;
    mem_wb_en_o   = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    wb_bubble_o   = 1'b0;
    if (reset_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      wb_bubble_o   = 1'b1;
    end else if (state_q != HALT) begin
      if (mem_hold) begin
        mem_wb_en_o = 1'b1;
        wb_bubble_o = 1'b1;
      end else if (ex_branch_taken_i) begin
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        id_ex_en_o    = 1'b1;
        ex_mem_en_o   = 1'b1;
        mem_wb_en_o   = 1'b1;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (data_hazard) begin
        id_ex_en_o    = 1'b1;
        ex_mem_en_o   = 1'b1;
        mem_wb_en_o   = 1'b1;
        id_ex_flush_o = 1'b1;
      end else begin
        pc_en_o     = 1'b1;
        if_id_en_o  = 1'b1;
        id_ex_en_o  = 1'b1;
        ex_mem_en_o = 1'b1;
        mem_wb_en_o = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((state_q != HALT) && !pc_en_o && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  assign state_o        = state_q;
  assign stall_cycles_o = stall_cycles_q;
  assign mem_timeout_o  = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (instance uses MEM_TIMEOUT=4).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        id_rs1_used, id_rs2_used, ex_reg_en, ex_is_load, mem_reg_en;
  logic        ex_branch_taken, mem_req, mem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, wb_bubble, mem_timeout;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] exp_stall = '0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clock_i(clk), .reset_i(reset),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .ex_rd_i(ex_rd), .ex_reg_en_i(ex_reg_en), .ex_is_load_i(ex_is_load),
    .mem_rd_i(mem_rd), .mem_reg_en_i(mem_reg_en),
    .ex_branch_taken_i(ex_branch_taken), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
    .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush), .wb_bubble_o(wb_bubble),
    .state_o(state), .stall_cycles_o(stall_cycles), .mem_timeout_o(mem_timeout)
  );

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd = '0; ex_reg_en = 0; ex_is_load = 0; mem_rd = '0; mem_reg_en = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    @(negedge clk); #1;
    n_cmp++; if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== 5'b00000) begin n_bad++; $display("FAIL reset_enables got %b want 00000", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}); end
    n_cmp++; if ({if_id_flush, id_ex_flush, wb_bubble} !== 3'b111) begin n_bad++; $display("FAIL reset_flushes got %b want 111", {if_id_flush, id_ex_flush, wb_bubble}); end
    @(posedge clk); #1;
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_stall got %0d want 0", stall_cycles); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %b want 0", mem_timeout); end
    @(negedge clk); reset = 0;
    #1;
    n_cmp++; if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, wb_bubble} !== 8'b11111000) begin n_bad++; $display("FAIL idle_outputs got %b want 11111000", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, wb_bubble}); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ex_is_load = 1; ex_reg_en = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
    #1;
    n_cmp++; if ({pc_en, if_id_en, id_ex_flush, ex_mem_en, mem_wb_en} !== 5'b00111) begin n_bad++; $display("FAIL load_use_ctrl got %b want 00111", {pc_en, if_id_en, id_ex_flush, ex_mem_en, mem_wb_en}); end
    @(posedge clk); #1; exp_stall += 1;
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL load_use_stall got %0d want %0d", stall_cycles, exp_stall); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_x0_unused();
    ex_is_load = 1; ex_reg_en = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1;
    #1;
    n_cmp++; if ({pc_en, if_id_en, id_ex_en, id_ex_flush} !== 4'b1110) begin n_bad++; $display("FAIL x0_nostall got %b want 1110", {pc_en, if_id_en, id_ex_en, id_ex_flush}); end
    @(negedge clk);
    ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 0;
    #1;
    n_cmp++; if ({pc_en, if_id_en, id_ex_en, id_ex_flush} !== 4'b1110) begin n_bad++; $display("FAIL unused_nostall got %b want 1110", {pc_en, if_id_en, id_ex_en, id_ex_flush}); end
    @(posedge clk); #1;
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL x0_unused_stall got %0d want %0d", stall_cycles, exp_stall); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_no_forwarding();
    logic exp_pc;
`ifdef PIPELINE_CTRL_FORWARDING_EN
    exp_pc = 1'b1;
`else
    exp_pc = 1'b0;
`endif
    ex_reg_en = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1;
    #1;
    n_cmp++; if (pc_en !== exp_pc) begin n_bad++; $display("FAIL nofwd_ex_stage got %b want %b", pc_en, exp_pc); end
    @(negedge clk);
    ex_reg_en = 0; ex_rd = '0; mem_rd = 5'd7; mem_reg_en = 1;
    #1;
    n_cmp++; if (pc_en !== exp_pc) begin n_bad++; $display("FAIL nofwd_mem_stage got %b want %b", pc_en, exp_pc); end
    @(negedge clk);
    mem_rd = '0; mem_reg_en = 0;
    #1;
    n_cmp++; if (pc_en !== 1'b1) begin n_bad++; $display("FAIL nofwd_release got %b want 1", pc_en); end
`ifndef PIPELINE_CTRL_FORWARDING_EN
    exp_stall += 2;
`endif
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL nofwd_stall got %0d want %0d", stall_cycles, exp_stall); end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    mem_req = 1; mem_ready = 1;
    #1;
    n_cmp++; if ({pc_en, wb_bubble} !== 2'b10) begin n_bad++; $display("FAIL mem_ready_nostall got %b want 10", {pc_en, wb_bubble}); end
    @(negedge clk);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, wb_bubble} !== 6'b000011) begin n_bad++; $display("FAIL mem_wait_ctrl[%0d] got %b want 000011", i, {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, wb_bubble}); end
      @(posedge clk); #1;
      n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL mem_wait_state[%0d] got %0d want 1", i, state); end
      @(negedge clk);
    end
    mem_ready = 1;
    #1;
    n_cmp++; if ({pc_en, wb_bubble} !== 2'b10) begin n_bad++; $display("FAIL mem_done_ctrl got %b want 10", {pc_en, wb_bubble}); end
    @(posedge clk); #1; exp_stall += 3;
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL mem_done_state got %0d want 0", state); end
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL mem_wait_stall got %0d want %0d", stall_cycles, exp_stall); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_branch_hazard();
    ex_branch_taken = 1; ex_is_load = 1; ex_reg_en = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 1;
    #1;
    n_cmp++; if ({pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush} !== 5'b11111) begin n_bad++; $display("FAIL branch_hazard_ctrl got %b want 11111", {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush}); end
    @(posedge clk); #1;
    n_cmp++; if (stall_cycles !== exp_stall) begin n_bad++; $display("FAIL branch_hazard_stall got %0d want %0d", stall_cycles, exp_stall); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_branch_mem();
    ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
    #1;
    n_cmp++; if ({pc_en, if_id_flush, id_ex_flush, wb_bubble} !== 4'b0001) begin n_bad++; $display("FAIL branch_mem_stall got %b want 0001", {pc_en, if_id_flush, id_ex_flush, wb_bubble}); end
    @(negedge clk);
    mem_ready = 1;
    #1;
    n_cmp++; if ({pc_en, if_id_flush, id_ex_flush, wb_bubble} !== 4'b1110) begin n_bad++; $display("FAIL branch_mem_flush got %b want 1110", {pc_en, if_id_flush, id_ex_flush, wb_bubble}); end
    @(posedge clk); #1; exp_stall += 1;
    n_cmp++; if ({state, stall_cycles} !== {2'd0, exp_stall}) begin n_bad++; $display("FAIL branch_mem_after got state %0d stall %0d want 0 %0d", state, stall_cycles, exp_stall); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_timeout();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (state !== ((i == 3) ? 2'd2 : 2'd1)) begin n_bad++; $display("FAIL timeout_state[%0d] got %0d want %0d", i, state, (i == 3) ? 2 : 1); end
    end
    exp_stall += 4;
    n_cmp++; if (mem_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_flag got %b want 1", mem_timeout); end
    n_cmp++; if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, wb_bubble} !== 8'b0) begin n_bad++; $display("FAIL halt_outputs got %b want 00000000", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, wb_bubble}); end
    @(negedge clk); mem_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({state, stall_cycles} !== {2'd2, exp_stall}) begin n_bad++; $display("FAIL halt_frozen got state %0d stall %0d want 2 %0d", state, stall_cycles, exp_stall); end
    @(negedge clk); reset = 1;
    @(posedge clk); #1; exp_stall = '0;
    n_cmp++; if ({state, mem_timeout, stall_cycles} !== {2'd0, 1'b0, exp_stall}) begin n_bad++; $display("FAIL halt_reset got state %0d to %b stall %0d want 0 0 0", state, mem_timeout, stall_cycles); end
    @(negedge clk); reset = 0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_unused();
    test_no_forwarding();
    test_mem_wait();
    test_branch_hazard();
    test_branch_mem();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
